// File: rtl/cpu_controller_if.sv
// Control bundle between the instruction-issue side and the datapath controller.
// master = controller (drives datapath strobes), slave = issuer/datapath observer.
interface cpu_controller_if #(
  parameter int DATA_W = 16
);
  logic              s;
  logic [15:0]       in;
  logic              w;
  logic              halted;
  logic [1:0]        vsel;
  logic              write;
  logic [2:0]        writenum;
  logic [2:0]        readnum;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic [1:0]        shift;
  logic [1:0]        ALUop;
  logic [DATA_W-1:0] sximm8;
  logic [DATA_W-1:0] sximm5;

  modport master (
    input  s, in,
    output w, halted, vsel, write, writenum, readnum, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm8, sximm5
  );

  modport slave (
    output s, in,
    input  w, halted, vsel, write, writenum, readnum, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm8, sximm5
  );
endinterface

// File: rtl/cpu_controller.sv
// Instruction decoder + Moore sequencer for the register-file/shifter/ALU datapath.
// Defining CPU_CTRL_HALT_EN makes opcode 111 enter a HALT state left only by reset_n.
module cpu_controller #(
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  cpu_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WR_IMM = 3'd2,
    S_GET_A  = 3'd3,
    S_GET_B  = 3'd4,
    S_EXEC   = 3'd5,
    S_WR_REG = 3'd6
`ifdef CPU_CTRL_HALT_EN
    , S_HALT = 3'd7
`endif
  } state_e;

  typedef struct packed {
    logic       w;
    logic [1:0] vsel;
    logic       write;
    logic [2:0] writenum;
    logic [2:0] readnum;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctl_t;

  localparam ctl_t CTL_RST = '{w: 1'b1, default: '0};

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ctl_t        ctl_q, ctl_d;

  function automatic state_e decode_target(input logic [15:0] ir);
    state_e nxt;
    nxt = S_WAIT;
    case (ir[15:13])
      3'b110: begin
        if (ir[12:11] == 2'b10)      nxt = S_WR_IMM;
        else if (ir[12:11] == 2'b00) nxt = S_GET_B;
      end
      3'b101: nxt = S_GET_A;
`ifdef CPU_CTRL_HALT_EN
      3'b111: nxt = S_HALT;
`endif
      default: nxt = S_WAIT;
    endcase
    return nxt;
  endfunction

  // Register indices keep their previous value outside the cycles that strobe them.
  function automatic ctl_t ctl_for(input state_e st, input logic [15:0] ir, input ctl_t prev);
    ctl_t c;
    c          = '0;
    c.readnum  = prev.readnum;
    c.writenum = prev.writenum;
    case (st)
      S_WAIT: c.w = 1'b1;
      S_WR_IMM: begin
        c.writenum = ir[10:8];
        c.vsel     = 2'b01;
        c.write    = 1'b1;
      end
      S_GET_A: begin
        c.readnum = ir[10:8];
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        c.readnum = ir[2:0];
        c.loadb   = 1'b1;
        c.shift   = ir[4:3];
      end
      S_EXEC: begin
        c.shift = ir[4:3];
        if (ir[15:13] == 3'b110) begin
          c.asel  = 1'b1;
          c.loadc = 1'b1;
        end else if (ir[12:11] == 2'b01) begin
          c.aluop = 2'b01;
          c.loads = 1'b1;
        end else begin
          c.aluop = ir[12:11];
          c.loadc = 1'b1;
        end
      end
      S_WR_REG: begin
        c.writenum = ir[7:5];
        c.vsel     = 2'b11;
        c.write    = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (bus.s) begin
          ir_d    = bus.in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = decode_target(ir_q);
      S_WR_IMM: state_d = S_WAIT;
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_EXEC;
      // CMP only updates status, so it skips the register write-back.
      S_EXEC:   state_d = (ir_q[15:13] == 3'b101 && ir_q[12:11] == 2'b01) ? S_WAIT : S_WR_REG;
      S_WR_REG: state_d = S_WAIT;
`ifdef CPU_CTRL_HALT_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_WAIT;
    endcase
    ctl_d = ctl_for(state_d, ir_d, ctl_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      ctl_q   <= CTL_RST;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctl_q   <= ctl_d;
    end
  end

  assign bus.w        = ctl_q.w;
  assign bus.vsel     = ctl_q.vsel;
  assign bus.write    = ctl_q.write;
  assign bus.writenum = ctl_q.writenum;
  assign bus.readnum  = ctl_q.readnum;
  assign bus.loada    = ctl_q.loada;
  assign bus.loadb    = ctl_q.loadb;
  assign bus.loadc    = ctl_q.loadc;
  assign bus.loads    = ctl_q.loads;
  assign bus.asel     = ctl_q.asel;
  assign bus.bsel     = 1'b0;
  assign bus.shift    = ctl_q.shift;
  assign bus.ALUop    = ctl_q.aluop;
  assign bus.sximm8   = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign bus.sximm5   = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};

`ifdef CPU_CTRL_HALT_EN
  assign bus.halted = (state_q == S_HALT);
`else
  assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: spec vectors, reset/hold/halt sequences, random instructions vs model.
module tb_cpu_controller;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cpu_controller_if #(.DATA_W(16)) bus ();
  cpu_controller #(.DATA_W(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Architectural view of one instruction: latency plus what each strobe did.
  typedef struct {
    int lat; int nwr; int wnum; int vsel;
    int nla; int ra; int nlb; int rb; int shb;
    int nlc; int nls; int alu; int asel; int sh;
    int odd; int sx8; int sx5;
  } res_t;

  typedef struct {
    logic [15:0] instr;
    res_t        exp;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic int busy();
    return int'(|{bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel,
                  bus.bsel, bus.halted, bus.vsel, bus.shift, bus.ALUop});
  endfunction

  function automatic res_t mkres(int lat, int nwr, int wnum, int vsel, int nla, int ra,
                                 int nlb, int rb, int nlc, int nls, int alu, int asel,
                                 int sh, int sx8, int sx5);
    res_t r;
    r = '{default: 0};
    r.lat = lat; r.nwr = nwr; r.wnum = wnum; r.vsel = vsel;
    r.nla = nla; r.ra = ra; r.nlb = nlb; r.rb = rb; r.shb = sh;
    r.nlc = nlc; r.nls = nls; r.alu = alu; r.asel = asel; r.sh = sh;
    r.sx8 = sx8; r.sx5 = sx5;
    return r;
  endfunction

  function automatic res_t model(input logic [15:0] ins);
    res_t r;
    int opc, op, rn, rd, sh, rm, v8, v5;
    r   = '{default: 0};
    opc = int'(ins[15:13]); op = int'(ins[12:11]); rn = int'(ins[10:8]);
    rd  = int'(ins[7:5]);   sh = int'(ins[4:3]);   rm = int'(ins[2:0]);
    v8  = int'(ins[7:0]);   v5 = int'(ins[4:0]);
    if (v8 >= 128) v8 -= 256;
    if (v5 >= 16)  v5 -= 32;
    r.sx8 = v8 & 'hFFFF;
    r.sx5 = v5 & 'hFFFF;
    r.lat = 2;
    if (opc == 6 && op == 2) begin
      r.lat = 3; r.nwr = 1; r.wnum = rn; r.vsel = 1;
    end else if (opc == 6 && op == 0) begin
      r.lat = 5; r.nlb = 1; r.rb = rm; r.shb = sh;
      r.nlc = 1; r.alu = 0; r.asel = 1; r.sh = sh;
      r.nwr = 1; r.wnum = rd; r.vsel = 3;
    end else if (opc == 5 && op == 1) begin
      r.lat = 5; r.nla = 1; r.ra = rn; r.nlb = 1; r.rb = rm; r.shb = sh;
      r.nls = 1; r.alu = 1; r.sh = sh;
    end else if (opc == 5) begin
      r.lat = 6; r.nla = 1; r.ra = rn; r.nlb = 1; r.rb = rm; r.shb = sh;
      r.nlc = 1; r.alu = op; r.sh = sh;
      r.nwr = 1; r.wnum = rd; r.vsel = 3;
    end
    return r;
  endfunction

  // Called at a negedge while the DUT idles in WAIT; returns at the negedge where w is back.
  task automatic run_instr(input logic [15:0] instr, output res_t r);
    r = '{default: 0};
    r.lat = -1;
    bus.s  = 1'b1;
    bus.in = instr;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.s = 1'b0;
        r.sx8 = int'(bus.sximm8);
        r.sx5 = int'(bus.sximm5);
      end
      if (bus.write) begin r.nwr++; r.wnum = int'(bus.writenum); r.vsel = int'(bus.vsel); end
      if (bus.loada) begin r.nla++; r.ra = int'(bus.readnum); end
      if (bus.loadb) begin r.nlb++; r.rb = int'(bus.readnum); r.shb = int'(bus.shift); end
      if (bus.loadc || bus.loads) begin
        r.alu = int'(bus.ALUop); r.asel = int'(bus.asel); r.sh = int'(bus.shift);
      end
      r.nlc += int'(bus.loadc);
      r.nls += int'(bus.loads);
      if (bus.bsel || bus.halted) r.odd++;
      if (bus.w) begin
        r.lat = c;
        if (busy() != 0) r.odd++;
        break;
      end
    end
  endtask

  task automatic cmp(input string t, input res_t g, input res_t e);
    chk({t, ".lat"}, g.lat, e.lat);
    chk({t, ".nwrite"}, g.nwr, e.nwr);
    chk({t, ".nloada"}, g.nla, e.nla);
    chk({t, ".nloadb"}, g.nlb, e.nlb);
    chk({t, ".nloadc"}, g.nlc, e.nlc);
    chk({t, ".nloads"}, g.nls, e.nls);
    chk({t, ".stray"}, g.odd, e.odd);
    chk({t, ".sximm8"}, g.sx8, e.sx8);
    chk({t, ".sximm5"}, g.sx5, e.sx5);
    if (e.nwr > 0) begin
      chk({t, ".writenum"}, g.wnum, e.wnum);
      chk({t, ".vsel"}, g.vsel, e.vsel);
    end
    if (e.nla > 0) chk({t, ".readnum_a"}, g.ra, e.ra);
    if (e.nlb > 0) begin
      chk({t, ".readnum_b"}, g.rb, e.rb);
      chk({t, ".shift_b"}, g.shb, e.shb);
    end
    if (e.nlc + e.nls > 0) begin
      chk({t, ".aluop"}, g.alu, e.alu);
      chk({t, ".asel"}, g.asel, e.asel);
      chk({t, ".shift_x"}, g.sh, e.sh);
    end
  endtask

  vec_t tbl[9];

  initial begin
    res_t r;
    int   nw, nl, nld, consec, first, prevw;
    logic [15:0] ins;
    int   k;

    tbl[0] = '{16'hD007, mkres(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0007, 'h0007)};
    tbl[1] = '{16'hD1FE, mkres(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hFFFE, 'hFFFE)};
    tbl[2] = '{16'hA148, mkres(6, 1, 2, 3, 1, 1, 1, 0, 1, 0, 0, 0, 1, 'h0048, 'h0008)};
    tbl[3] = '{16'hA801, mkres(5, 0, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0, 'h0001, 'h0001)};
    tbl[4] = '{16'hC0E9, mkres(5, 1, 7, 3, 0, 0, 1, 1, 1, 0, 0, 1, 1, 'hFFE9, 'h0009)};
    tbl[5] = '{16'hB4B2, mkres(6, 1, 5, 3, 1, 4, 1, 2, 1, 0, 2, 0, 2, 'hFFB2, 'hFFF2)};
    tbl[6] = '{16'hBFFF, mkres(6, 1, 7, 3, 1, 7, 1, 7, 1, 0, 3, 0, 3, 'hFFFF, 'hFFFF)};
    tbl[7] = '{16'h0000, mkres(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0000, 'h0000)};
    tbl[8] = '{16'hD8FF, mkres(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 'hFFFF)};

    // Reset state, with s already high so the first post-release edge must accept it.
    reset_n = 1'b0;
    bus.s   = 1'b1;
    bus.in  = 16'hD007;
    @(negedge clk);
    chk("reset.w", int'(bus.w), 1);
    chk("reset.quiet", busy(), 0);
    @(negedge clk);
    chk("reset.still_w", int'(bus.w), 1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("release.first_s_accepted", int'(bus.w), 0);
    bus.s = 1'b0;
    @(negedge clk);
    chk("release.movi_write", int'(bus.write), 1);
    chk("release.movi_writenum", int'(bus.writenum), 0);
    chk("release.movi_vsel", int'(bus.vsel), 1);
    chk("release.movi_sximm8", int'(bus.sximm8), 'h0007);
    @(negedge clk);
    chk("release.movi_w_at_3", int'(bus.w), 1);

    foreach (tbl[i]) begin
      run_instr(tbl[i].instr, r);
      cmp($sformatf("vec%0d_%04h", i, tbl[i].instr), r, tbl[i].exp);
    end

    // s held high: one CMP accepted per WAIT visit, WAIT lasts a single cycle.
    bus.s = 1'b1; bus.in = 16'hA801;
    nw = 0; nld = 0; consec = 0; first = 0; prevw = 0; nl = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.w && prevw == 1) consec++;
      if (bus.w && first == 0) first = c;
      nw  += int'(bus.w);
      nld += int'(bus.loads);
      nl  += int'(bus.write);
      prevw = int'(bus.w);
    end
    bus.s = 1'b0;
    chk("hold.first_w", first, 5);
    chk("hold.w_cycles", nw, 4);
    chk("hold.loads", nld, 4);
    chk("hold.writes", nl, 0);
    chk("hold.consecutive_w", consec, 0);

    // Reset during GET_B of an ADD: abort with no write-back.
    bus.s = 1'b1; bus.in = 16'hA148;
    @(negedge clk); bus.s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.in_getb", int'(bus.loadb), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort.rst_w", int'(bus.w), 1);
    chk("abort.rst_quiet", busy(), 0);
    chk("abort.rst_ir", int'(bus.sximm8), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    nw = 0; nl = 0;
    repeat (8) begin
      @(negedge clk);
      nw += int'(bus.write);
      if (!bus.w) nl++;
    end
    chk("abort.no_write_after", nw, 0);
    chk("abort.w_stays_high", nl, 0);

    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ins = 16'($urandom);
      k   = $urandom_range(0, 9);
      if (k < 4) ins[15:13] = 3'b101;
      else if (k < 7) begin
        ins[15:13] = 3'b110;
        ins[12:11] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : ((k == 4) ? 2'b10 : 2'b00);
      end
`ifdef CPU_CTRL_HALT_EN
      if (ins[15:13] == 3'b111) ins[15:13] = 3'b000;
`endif
      run_instr(ins, r);
      cmp($sformatf("rnd%0d_%04h", n, ins), r, model(ins));
    end

`ifdef CPU_CTRL_HALT_EN
    bus.s = 1'b1; bus.in = 16'hE000;
    nw = 0; nl = 0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      bus.in = 16'hD007;
      if (c >= 2 && bus.halted && !bus.w) nw++;
      nl += int'(bus.write);
    end
    bus.s = 1'b0;
    chk("halt.cycles", nw, 20);
    chk("halt.writes", nl, 0);
    reset_n = 1'b0;
    #1;
    chk("halt.reset_halted", int'(bus.halted), 0);
    chk("halt.reset_w", int'(bus.w), 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
`else
    run_instr(16'hE000, r);
    cmp("op111_unrecognised", r, mkres(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
